// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 9-bit UART receiver with mid-bit oversampling and a valid/ack output
// Frame: start(0), 9 data bits LSB first, stop(1); idle line high.
module uart_rx #(
  parameter int CLK_HZ      = 25_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int SAMPLE_RATE = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [8:0] data,
  output logic       data_valid,
  input  logic       data_ack,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
);

  localparam int DIVISOR = CLK_HZ / (BAUD_RATE * SAMPLE_RATE);
  localparam int DIV_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int SAMP_W  = $clog2(SAMPLE_RATE);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIVISOR - 1);
  localparam logic [SAMP_W-1:0] SAMP_MID  = SAMP_W'(SAMPLE_RATE / 2 - 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SAMPLE_RATE - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t              r_state;
  logic [1:0]          r_sync;
  logic [DIV_W-1:0]    r_div_cnt;
  logic [SAMP_W-1:0]   r_samp_cnt;
  logic [3:0]          r_bit_cnt;
  logic [8:0]          r_shreg;
  logic [8:0]          r_data;
  logic                r_data_valid;
  logic                r_framing_error;
  logic                r_overrun;

  logic w_rx_s;
  logic w_tick;

  assign w_rx_s = r_sync[1];
  assign w_tick = (r_div_cnt == DIV_LAST);

  assign data          = r_data;
  assign data_valid    = r_data_valid;
  assign framing_error = r_framing_error;
  assign overrun       = r_overrun;
  assign busy          = (r_state != S_IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_sync          <= 2'b11;
      r_div_cnt       <= '0;
      r_samp_cnt      <= '0;
      r_bit_cnt       <= '0;
      r_shreg         <= '0;
      r_data          <= '0;
      r_data_valid    <= 1'b0;
      r_framing_error <= 1'b0;
      r_overrun       <= 1'b0;
    end else begin
      r_sync          <= {r_sync[0], rx};
      r_framing_error <= 1'b0;
      r_overrun       <= 1'b0;

      if (r_data_valid && data_ack)
        r_data_valid <= 1'b0;

      if (r_state == S_IDLE || r_state == S_BREAK || w_tick)
        r_div_cnt <= '0;
      else
        r_div_cnt <= r_div_cnt + 1'b1;

      // A load later in this block overrides the ack clear: the new word wins.
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_state    <= S_START;
            r_samp_cnt <= '0;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (r_samp_cnt == SAMP_MID) begin
              r_samp_cnt <= '0;
              r_bit_cnt  <= '0;
              r_state    <= w_rx_s ? S_IDLE : S_DATA;
            end else begin
              r_samp_cnt <= r_samp_cnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_samp_cnt == SAMP_LAST) begin
              r_samp_cnt <= '0;
              r_shreg    <= {w_rx_s, r_shreg[8:1]};
              if (r_bit_cnt == 4'd8)
                r_state <= S_STOP;
              else
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end else begin
              r_samp_cnt <= r_samp_cnt + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (r_samp_cnt == SAMP_LAST) begin
              r_samp_cnt <= '0;
              if (w_rx_s) begin
                r_data       <= r_shreg;
                r_data_valid <= 1'b1;
                r_overrun    <= r_data_valid && !data_ack;
                r_state      <= S_IDLE;
              end else begin
                r_framing_error <= 1'b1;
                r_state         <= S_BREAK;
              end
            end else begin
              r_samp_cnt <= r_samp_cnt + 1'b1;
            end
          end
        end
        S_BREAK: begin
          if (w_rx_s)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
